wb_load_stage: RTL and testbench
================================

WB_LOAD_STAGE -- requirements
Module: wb_load_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of clk_en-qualified cycles to wait for i_mem_ack before faulting; legal range 1..255.
REQ-002 SHALL have clocking: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset; dominates clk_en.
REQ-005 clk_en  input  1  global advance enable; all state, counter and output registers update only when clk_en=1.
REQ-006 i_valid  input  1  upstream op valid.
REQ-007 o_ready  output  1  op accepted when i_valid & o_ready & clk_en.
REQ-008 i_rd  input  5  destination register.
REQ-009 i_result  input  32  ALU result, or byte address for loads.
REQ-010 i_is_load  input  1  op is a load.
REQ-011 i_funct3  input  3  load width/sign code; ignored for non-loads.
REQ-012 o_mem_req  output  1  data-memory read request, held until ack or abort.
REQ-013 o_mem_addr  output  32  word-aligned read address.
REQ-014 i_mem_ack  input  1  read data valid this cycle.
REQ-015 i_mem_rdata  input  32  read word.
REQ-016 o_write_addr  output  5  register-file write address.
REQ-017 o_write_data  output  32  register-file write data.
REQ-018 o_write_en  output  1  register-file write strobe.
REQ-019 o_fault  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout.

Function
REQ-020 SHALL implement states IDLE and LOAD; o_ready=1 exactly in IDLE.
REQ-021 Non-load accepted at cycle N: o_write_en=1, o_write_addr=i_rd, o_write_data=i_result at N+1; state stays IDLE, so back-to-back ops achieve one write per cycle.
REQ-022 o_write_en, o_fault are registered pulses lasting exactly one clk_en=1 cycle; while clk_en=0 all outputs hold their values.
REQ-023 An op with rd=0 SHALL complete normally but never assert o_write_en.
REQ-024 Load accepted with legal funct3 and aligned address: next cycle state=LOAD, o_mem_req=1, o_mem_addr={i_result[31:2],2'b00}; rd, funct3 and address bits [1:0] captured.
REQ-025 Alignment: LH/LHU require addr[0]=0; LW requires addr[1:0]=0; LB/LBU always aligned.
REQ-026 funct3 in {011,110,111}, or a misaligned load, SHALL pulse o_fault the next cycle, issue no request, no write, stay IDLE.
REQ-027 In LOAD, on i_mem_ack (sampled when clk_en=1): o_mem_req=0, state=IDLE, o_write_en pulse with extracted data next cycle.
REQ-028 Extraction: 000 LB = sign-extended byte at bit offset addr[1:0]*8; 100 LBU = zero-extended byte; 001 LH = sign-extended half at bit offset addr[1]*16; 101 LHU = zero-extended half; 010 LW = whole word.
REQ-029 Timeout counter clears on entering LOAD, increments each clk_en=1 cycle in LOAD without ack; reaching TIMEOUT_CYCLES SHALL drop o_mem_req, pulse o_fault, no write, return IDLE.
REQ-030 Ack in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins, no fault.
REQ-031 i_mem_ack while IDLE SHALL be ignored.

Reset
REQ-032 On rst: state=IDLE, counter=0, o_mem_req=0, o_mem_addr=0, o_write_en=0, o_write_addr=0, o_write_data=0, o_fault=0; o_ready=1 after reset.
REQ-033 rst during LOAD SHALL abandon the load: no write, no fault; a later ack is ignored.

Verification
REQ-034 ALU op rd=5, result 0x12345678 -> next cycle o_write_en=1, addr 5, data 0x12345678; a following op is accepted the same cycle.
REQ-035 LB addr 0x00001003, ack after 3 cycles with rdata 0x80FF0000 -> o_mem_addr 0x00001000, write data 0xFFFFFF80.
REQ-036 LHU addr 0x00002002, rdata 0xBEEF1234 -> write data 0x0000BEEF; LH with the same stimulus -> 0xFFFFBEEF.
REQ-037 LW addr 0x00001001 -> o_fault pulse, o_mem_req never asserted, no write.
REQ-038 TIMEOUT_CYCLES=4, no ack -> o_mem_req high 4 clk_en cycles, then o_fault pulse, IDLE; repeat with ack on 4th cycle -> write, no fault.
REQ-039 ALU op rd=0 -> no o_write_en; clk_en=0 held 3 cycles mid-load -> counter and outputs frozen.

Source files
------------

// File: rtl/wb_load_stage.sv
// Writeback / load stage: forwards ALU results to the register file and
// performs a single outstanding data-memory read for loads, extracting the
// requested byte/half/word. Misaligned loads, illegal widths and memory
// timeouts raise a one-cycle fault pulse instead of a write.
module wb_load_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_result,
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [4:0]  o_write_addr,
  output logic [31:0] o_write_data,
  output logic        o_write_en,
  output logic        o_fault
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [4:0]  r_write_addr;
  logic [31:0] r_write_data;
  logic        r_write_en;
  logic        r_fault;

  logic        w_f3_legal;
  logic        w_misaligned;
  logic [7:0]  w_cnt_next;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Request checks for the op currently presented upstream.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_f3_legal   = 1'b0;
    w_misaligned = 1'b0;
    unique case (i_funct3)
      3'b000, 3'b100: w_f3_legal = 1'b1;
      3'b001, 3'b101: begin
        w_f3_legal   = 1'b1;
        w_misaligned = i_result[0];
      end
      3'b010: begin
        w_f3_legal   = 1'b1;
        w_misaligned = |i_result[1:0];
      end
      default: w_f3_legal = 1'b0;
    endcase
  end

  // Byte/half lane selection and sign/zero extension of the returned word.
  always_comb begin
    w_load_data = i_mem_rdata;
    unique case (r_off)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    unique case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  assign w_cnt_next = r_cnt + 8'd1;

  // Stage FSM with all outputs registered; nothing moves while clk_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_write_addr <= 5'd0;
      r_write_data <= 32'd0;
      r_write_en   <= 1'b0;
      r_fault      <= 1'b0;
    end else if (clk_en) begin
      r_write_en <= 1'b0;
      r_fault    <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            if (!i_is_load) begin
              if (i_rd != 5'd0) begin
                r_write_en   <= 1'b1;
                r_write_addr <= i_rd;
                r_write_data <= i_result;
              end
            end else if (!w_f3_legal || w_misaligned) begin
              r_fault <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {i_result[31:2], 2'b00};
              r_rd       <= i_rd;
              r_funct3   <= i_funct3;
              r_off      <= i_result[1:0];
              r_cnt      <= 8'd0;
            end
          end
        end
        ST_LOAD: begin
          if (i_mem_ack) begin
            // Ack takes priority over a timeout expiring in the same cycle.
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            if (r_rd != 5'd0) begin
              r_write_en   <= 1'b1;
              r_write_addr <= r_rd;
              r_write_data <= w_load_data;
            end
          end else if (w_cnt_next == LP_TIMEOUT) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_fault   <= 1'b1;
            r_cnt     <= w_cnt_next;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready      = (r_state == ST_IDLE);
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_write_addr = r_write_addr;
  assign o_write_data = r_write_data;
  assign o_write_en   = r_write_en;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_wb_load_stage.sv
// Directed bench for wb_load_stage with a short memory timeout.
module tb_wb_load_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd;
  logic [31:0] i_result;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [4:0]  o_write_addr;
  logic [31:0] o_write_data;
  logic        o_write_en;
  logic        o_fault;

  int checks = 0;
  int errors = 0;

  wb_load_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_rd         (i_rd),
    .i_result     (i_result),
    .i_is_load    (i_is_load),
    .i_funct3     (i_funct3),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_write_addr (o_write_addr),
    .o_write_data (o_write_data),
    .o_write_en   (o_write_en),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle.
  task automatic issue(input logic ld, input logic [4:0] rd,
                       input logic [31:0] res, input logic [2:0] f3);
    i_valid = 1'b1; i_is_load = ld; i_rd = rd; i_result = res; i_funct3 = f3;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; i_valid = 1'b0; i_rd = 5'd0; i_result = 32'd0;
    i_is_load = 1'b0; i_funct3 = 3'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0; clk_en = 1'b1;
    checks++;
    if (o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_mem_addr !== 32'd0 ||
        o_write_en !== 1'b0 || o_write_addr !== 5'd0 || o_write_data !== 32'd0 ||
        o_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b req=%b addr=%h we=%b waddr=%0d wdata=%h fault=%b (want 1 0 0 0 0 0 0)",
               o_ready, o_mem_req, o_mem_addr, o_write_en, o_write_addr, o_write_data, o_fault);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 5'd5, 32'h1234_5678, 3'd0);
    checks++;
    if (o_write_en !== 1'b1 || o_write_addr !== 5'd5 || o_write_data !== 32'h1234_5678 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_first: we=%b addr=%0d data=%h ready=%b (want 1 5 12345678 1)",
               o_write_en, o_write_addr, o_write_data, o_ready);
    end
    issue(1'b0, 5'd6, 32'hA5A5_0F0F, 3'd0);
    checks++;
    if (o_write_en !== 1'b1 || o_write_addr !== 5'd6 || o_write_data !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL alu_second: we=%b addr=%0d data=%h (want 1 6 a5a50f0f)",
               o_write_en, o_write_addr, o_write_data);
    end
    tick();
    checks++;
    if (o_write_en !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse: we=%b (want 0)", o_write_en);
    end
    issue(1'b0, 5'd0, 32'hDEAD_BEEF, 3'd0);
    checks++;
    if (o_write_en !== 1'b0 || o_fault !== 1'b0) begin
      errors++;
      $display("FAIL alu_rd0: we=%b fault=%b (want 0 0)", o_write_en, o_fault);
    end
  endtask

  // Load that is acked after 'wait_cycles' extra LOAD cycles; checks the write.
  task automatic load_and_check(input string name, input logic [4:0] rd,
                                input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] rdata, input int wait_cycles,
                                input logic [31:0] exp_data);
    issue(1'b1, rd, addr, f3);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== {addr[31:2], 2'b00} || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_req: req=%b addr=%h ready=%b (want 1 %h 0)",
               name, o_mem_req, o_mem_addr, o_ready, {addr[31:2], 2'b00});
    end
    for (int i = 0; i < wait_cycles; i++) tick();
    i_mem_ack = 1'b1; i_mem_rdata = rdata;
    tick();
    i_mem_ack = 1'b0;
    checks++;
    if (o_write_en !== 1'b1 || o_write_addr !== rd || o_write_data !== exp_data ||
        o_mem_req !== 1'b0 || o_fault !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_data: we=%b addr=%0d data=%h req=%b fault=%b ready=%b (want 1 %0d %h 0 0 1)",
               name, o_write_en, o_write_addr, o_write_data, o_mem_req, o_fault, o_ready, rd, exp_data);
    end
  endtask

  task automatic test_loads();
    load_and_check("lb", 5'd7, 32'h0000_1003, 3'b000, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    load_and_check("lhu", 5'd8, 32'h0000_2002, 3'b101, 32'hBEEF_1234, 0, 32'h0000_BEEF);
    load_and_check("lh", 5'd9, 32'h0000_2002, 3'b001, 32'hBEEF_1234, 0, 32'hFFFF_BEEF);
    load_and_check("lbu", 5'd10, 32'h0000_1002, 3'b100, 32'h80FF_0000, 1, 32'h0000_00FF);
    load_and_check("lh_lo", 5'd11, 32'h0000_2000, 3'b001, 32'hBEEF_8234, 0, 32'hFFFF_8234);
    load_and_check("lw", 5'd12, 32'h0000_3000, 3'b010, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    // Stray ack while idle must not produce a write.
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    checks++;
    if (o_write_en !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: we=%b req=%b (want 0 0)", o_write_en, o_mem_req);
    end
  endtask

  // Rejected load: fault pulse, no request, no write, still idle.
  task automatic fault_case(input string name, input logic [31:0] addr, input logic [2:0] f3);
    issue(1'b1, 5'd3, addr, f3);
    checks++;
    if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_write_en !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: fault=%b req=%b we=%b ready=%b (want 1 0 0 1)",
               name, o_fault, o_mem_req, o_write_en, o_ready);
    end
    tick();
    checks++;
    if (o_fault !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: fault=%b req=%b (want 0 0)", name, o_fault, o_mem_req);
    end
  endtask

  task automatic test_faults();
    fault_case("lw_misaligned", 32'h0000_1001, 3'b010);
    fault_case("lh_misaligned", 32'h0000_1003, 3'b001);
    fault_case("f3_011", 32'h0000_1000, 3'b011);
    fault_case("f3_110", 32'h0000_1000, 3'b110);
  endtask

  task automatic test_timeout();
    issue(1'b1, 5'd4, 32'h0000_4000, 3'b010);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_mem_req !== 1'b1 || o_fault !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold%0d: req=%b fault=%b (want 1 0)", i, o_mem_req, o_fault);
      end
      if (i < 3) tick();
    end
    tick();
    checks++;
    if (o_mem_req !== 1'b0 || o_fault !== 1'b1 || o_write_en !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fault: req=%b fault=%b we=%b ready=%b (want 0 1 0 1)",
               o_mem_req, o_fault, o_write_en, o_ready);
    end
    tick();
    checks++;
    if (o_fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: fault=%b (want 0)", o_fault);
    end
    // Ack on the last allowed cycle wins over the timeout.
    load_and_check("ack_at_limit", 5'd13, 32'h0000_4004, 3'b010, 32'h1357_9BDF, 3, 32'h1357_9BDF);
  endtask

  task automatic test_clk_en();
    issue(1'b1, 5'd14, 32'h0000_5000, 3'b010);
    tick();
    clk_en = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
    tick(); tick(); tick();
    clk_en = 1'b1; i_mem_ack = 1'b0;
    checks++;
    if (o_mem_req !== 1'b1 || o_write_en !== 1'b0 || o_fault !== 1'b0) begin
      errors++;
      $display("FAIL freeze_load: req=%b we=%b fault=%b (want 1 0 0)", o_mem_req, o_write_en, o_fault);
    end
    tick(); tick();
    checks++;
    if (o_mem_req !== 1'b1 || o_fault !== 1'b0) begin
      errors++;
      $display("FAIL freeze_count: req=%b fault=%b (want 1 0)", o_mem_req, o_fault);
    end
    tick();
    checks++;
    if (o_fault !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL freeze_timeout: fault=%b req=%b (want 1 0)", o_fault, o_mem_req);
    end
    // A write pulse is held while clk_en is low.
    issue(1'b0, 5'd15, 32'h0F0F_0F0F, 3'd0);
    clk_en = 1'b0;
    tick(); tick();
    checks++;
    if (o_write_en !== 1'b1 || o_write_addr !== 5'd15 || o_write_data !== 32'h0F0F_0F0F) begin
      errors++;
      $display("FAIL freeze_write: we=%b addr=%0d data=%h (want 1 15 0f0f0f0f)",
               o_write_en, o_write_addr, o_write_data);
    end
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_rst_load();
    issue(1'b1, 5'd16, 32'h0000_6000, 3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (o_mem_req !== 1'b0 || o_ready !== 1'b1 || o_fault !== 1'b0 || o_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_load: req=%b ready=%b fault=%b we=%b (want 0 1 0 0)",
               o_mem_req, o_ready, o_fault, o_write_en);
    end
    i_mem_ack = 1'b1; i_mem_rdata = 32'h7777_7777;
    tick();
    i_mem_ack = 1'b0;
    checks++;
    if (o_write_en !== 1'b0 || o_fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_ack: we=%b fault=%b (want 0 0)", o_write_en, o_fault);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_loads();
    test_faults();
    test_timeout();
    test_clk_en();
    test_rst_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
